pcma_rom_sched: RTL and testbench



---
 rtl/pcma_rom_sched_if.sv | 29 ++
 rtl/pcma_rom_sched.sv | 157 +++++++++++++++
 tb/tb_pcma_rom_sched.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pcma_rom_sched_if.sv
// ADPCM-A sample ROM bus bundle: per-channel requests and the multiplexed ROM pins.
// RAD is carried as separate out/enable/in lanes; the bidirectional buffer sits in
// the pad ring, and rad_oe low means the pin is released (high-Z).
interface pcma_rom_sched_if;
    logic [5:0]   req;      // per-channel read request
    logic [131:0] ch_addr;  // channel n address at [22n+21:22n]
    logic [7:0]   rad_o;    // RAD value driven onto the pin
    logic         rad_oe;   // RAD output enable
    logic [7:0]   rad_i;    // RAD value read from the pin
    logic [5:0]   ra;       // upper address lines
    logic         rmpx;     // address latch strobe
    logic         nroe;     // ROM output enable, active low
    logic [5:0]   ack;      // one-cycle data-valid pulse per channel
    logic [7:0]   rdata;    // last byte read
    logic [2:0]   slot_ch;  // channel owning the bus
    logic         frame;    // pulse after channel 5's slot

    // Requesters and ROM side
    modport master (
        output req, ch_addr, rad_i,
        input  rad_o, rad_oe, ra, rmpx, nroe, ack, rdata, slot_ch, frame
    );

    // Scheduler side
    modport slave (
        input  req, ch_addr, rad_i,
        output rad_o, rad_oe, ra, rmpx, nroe, ack, rdata, slot_ch, frame
    );
endinterface

// File: rtl/pcma_rom_sched.sv
// Time-division scheduler for the shared ADPCM-A sample ROM bus.
// Six channels take turns in fixed order; each slot is six phases of DIV clocks.
// The channel's request and 22-bit address are committed at slot start, the address
// goes out in two halves framed by RMPX, and one byte is read back while nROE is low.
module pcma_rom_sched #(
    parameter int unsigned DIV = 12
) (
    input  logic             phi_m_i,
    input  logic             nreset_i,
    pcma_rom_sched_if.slave  bus
);

    localparam int unsigned     DivW    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DivW-1:0] DivLast = DivW'(DIV - 1);

    logic [DivW-1:0] div_q, div_d;
    logic [2:0]      phase_q, phase_d;
    logic [2:0]      ch_q, ch_d;
    logic            started_q;
    logic            active_q, active_d;
    logic [21:0]     addr_q, addr_d;
    logic [7:0]      rdata_q, rdata_d;
    logic [5:0]      ack_q, ack_d;
    logic            frame_q, frame_d;

    logic            phase_end;
    logic            slot_end;
    logic            commit;
    logic            capture;
    logic            sel_req;
    logic [21:0]     sel_addr;

    // Counter advance; the first edge after reset only commits slot 0 and holds at P0/div 0.
    always_comb begin
        phase_end = started_q && (div_q == DivLast);
        slot_end  = phase_end && (phase_q == 3'd5);

        div_d = '0;
        if (started_q && (div_q != DivLast)) begin
            div_d = div_q + 1'b1;
        end

        phase_d = phase_q;
        if (phase_end) begin
            phase_d = (phase_q == 3'd5) ? 3'd0 : phase_q + 3'd1;
        end

        ch_d = ch_q;
        if (slot_end) begin
            ch_d = (ch_q == 3'd5) ? 3'd0 : ch_q + 3'd1;
        end
    end

    // Select request and address of the channel whose slot starts next.
    always_comb begin
        sel_req  = 1'b0;
        sel_addr = '0;
        case (ch_d)
            3'd0: begin sel_req = bus.req[0]; sel_addr = bus.ch_addr[21:0];    end
            3'd1: begin sel_req = bus.req[1]; sel_addr = bus.ch_addr[43:22];   end
            3'd2: begin sel_req = bus.req[2]; sel_addr = bus.ch_addr[65:44];   end
            3'd3: begin sel_req = bus.req[3]; sel_addr = bus.ch_addr[87:66];   end
            3'd4: begin sel_req = bus.req[4]; sel_addr = bus.ch_addr[109:88];  end
            3'd5: begin sel_req = bus.req[5]; sel_addr = bus.ch_addr[131:110]; end
            default: begin sel_req = 1'b0; sel_addr = '0; end
        endcase
    end

    // Slot commit, data capture at the end of P5, and the frame pulse.
    always_comb begin
        commit   = !started_q || slot_end;
        capture  = slot_end && active_q;

        active_d = commit ? sel_req : active_q;
        addr_d   = commit ? sel_addr : addr_q;
        ack_d    = capture ? (6'd1 << ch_q) : 6'd0;
        rdata_d  = capture ? bus.rad_i : rdata_q;
        frame_d  = slot_end && (ch_q == 3'd5);
    end

    // All scheduler state; reset aborts any access in flight.
    always_ff @(posedge phi_m_i or negedge nreset_i) begin
        if (!nreset_i) begin
            div_q     <= '0;
            phase_q   <= 3'd0;
            ch_q      <= 3'd0;
            started_q <= 1'b0;
            active_q  <= 1'b0;
            addr_q    <= '0;
            rdata_q   <= 8'h00;
            ack_q     <= 6'd0;
            frame_q   <= 1'b0;
        end else begin
            div_q     <= div_d;
            phase_q   <= phase_d;
            ch_q      <= ch_d;
            started_q <= 1'b1;
            active_q  <= active_d;
            addr_q    <= addr_d;
            rdata_q   <= rdata_d;
            ack_q     <= ack_d;
            frame_q   <= frame_d;
        end
    end

    // Pin decode from registered phase and committed slot content only.
    always_comb begin
        bus.rad_o  = 8'h00;
        bus.rad_oe = 1'b0;
        bus.ra     = 6'h00;
        bus.rmpx   = 1'b0;
        bus.nroe   = 1'b1;
        if (active_q) begin
            case (phase_q)
                3'd0: begin
                    bus.rad_o  = addr_q[7:0];
                    bus.rad_oe = 1'b1;
                    bus.ra     = {4'h0, addr_q[9:8]};
                end
                3'd1: begin
                    bus.rad_o  = addr_q[7:0];
                    bus.rad_oe = 1'b1;
                    bus.ra     = {4'h0, addr_q[9:8]};
                    bus.rmpx   = 1'b1;
                end
                3'd2: begin
                    bus.rad_o  = addr_q[17:10];
                    bus.rad_oe = 1'b1;
                    bus.ra     = {2'h0, addr_q[21:18]};
                    bus.rmpx   = 1'b1;
                end
                3'd3: begin
                    bus.rad_o  = addr_q[17:10];
                    bus.rad_oe = 1'b1;
                    bus.ra     = {2'h0, addr_q[21:18]};
                end
                3'd4, 3'd5: begin
                    // ROM drives RAD; keep RA at the high half so it stays stable.
                    bus.ra     = {2'h0, addr_q[21:18]};
                    bus.nroe   = 1'b0;
                end
                default: begin
                    bus.rad_oe = 1'b0;
                end
            endcase
        end
    end

    // Status outputs straight from registers.
    always_comb begin
        bus.ack     = ack_q;
        bus.rdata   = rdata_q;
        bus.slot_ch = ch_q;
        bus.frame   = frame_q;
    end

endmodule

// File: tb/tb_pcma_rom_sched.sv
// Bench for pcma_rom_sched: a cycle-number model of the rotation checks every
// output each cycle, a latching ROM model answers reads, and directed literal
// checks pin the key cycles. A second instance runs with DIV = 4.
module tb_pcma_rom_sched;

    localparam int D  = 12;
    localparam int SL = 6 * D;

    logic clk;
    logic nreset;
    logic nreset2;
    int   checks;
    int   errors;
    int   cyc;

    logic [21:0] addr_tab [6];

    pcma_rom_sched_if bif ();
    pcma_rom_sched_if bif2 ();

    pcma_rom_sched #(.DIV(12)) u_dut (
        .phi_m_i  (clk),
        .nreset_i (nreset),
        .bus      (bif)
    );

    pcma_rom_sched #(.DIV(4)) u_dut4 (
        .phi_m_i  (clk),
        .nreset_i (nreset2),
        .bus      (bif2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bif.ch_addr  = {addr_tab[5], addr_tab[4], addr_tab[3],
                           addr_tab[2], addr_tab[1], addr_tab[0]};
    assign bif2.ch_addr = {22'h1F00F1, 110'h0};
    assign bif2.rad_i   = bif2.nroe ? 8'hEE : 8'h3C;

    function automatic logic [7:0] rom_byte(input logic [21:0] a);
        if (a == 22'h2ABCDE) return 8'h5A;
        return a[7:0] ^ a[15:8] ^ {2'b00, a[21:16]};
    endfunction

    // ROM: latches address halves on RMPX edges, drives data while nROE is low.
    logic [9:0]  rom_lo;
    logic [11:0] rom_hi;
    initial begin
        rom_lo = '0;
        rom_hi = '0;
    end
    always @(posedge bif.rmpx) rom_lo <= bif.rad_oe ? {bif.ra[1:0], bif.rad_o} : 10'h3FF;
    always @(negedge bif.rmpx) rom_hi <= bif.rad_oe ? {bif.ra[3:0], bif.rad_o} : 12'hFFF;
    assign bif.rad_i = bif.nroe ? 8'hEE : rom_byte({rom_hi, rom_lo});

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at t=%0t cycle %0d", name, act, exp, $time, cyc);
        end
    endtask

    // Model: cycle k (after the k-th edge since release) is slot (k-1)/SL, phase ((k-1)%SL)/D.
    logic        m_active;
    logic [21:0] m_addr;
    logic [5:0]  m_ack;
    logic [7:0]  m_rdata;
    logic        m_frame;

    always @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            cyc      <= 0;
            m_active <= 1'b0;
            m_addr   <= '0;
            m_ack    <= '0;
            m_rdata  <= '0;
            m_frame  <= 1'b0;
        end else begin
            cyc     <= cyc + 1;
            m_ack   <= (cyc != 0 && cyc % SL == 0 && m_active) ?
                       (6'd1 << (((cyc - 1) / SL) % 6)) : 6'd0;
            m_frame <= (cyc != 0 && cyc % (6 * SL) == 0);
            if (cyc != 0 && cyc % SL == 0 && m_active) m_rdata <= rom_byte(m_addr);
            if (cyc % SL == 0) begin
                m_active <= bif.req[3'((cyc / SL) % 6)];
                m_addr   <= addr_tab[3'((cyc / SL) % 6)];
            end
        end
    end

    // {slot_ch, frame, ack, rdata, rmpx, nroe, ra, rad_oe, rad}
    function automatic logic [34:0] exp_vec(input int k, input logic act, input logic [21:0] a,
                                            input logic [5:0] ack, input logic [7:0] rd,
                                            input logic fr);
        logic [2:0] sc;
        int         ph;
        logic       rmpx, nroe, oe;
        logic [5:0] ra;
        logic [7:0] rad;
        sc   = (k == 0) ? 3'd0 : 3'(((k - 1) / SL) % 6);
        ph   = (k == 0) ? 0 : ((k - 1) % SL) / D;
        rmpx = 1'b0; nroe = 1'b1; oe = 1'b0; ra = 6'h00; rad = 8'h00;
        if (k != 0 && act) begin
            if (ph < 2) begin
                oe = 1'b1; rad = a[7:0]; ra = {4'h0, a[9:8]};
            end else if (ph < 4) begin
                oe = 1'b1; rad = a[17:10]; ra = {2'h0, a[21:18]};
            end else begin
                nroe = 1'b0; ra = {2'h0, a[21:18]};
            end
            rmpx = (ph == 1 || ph == 2);
        end
        return {sc, fr, ack, rd, rmpx, nroe, ra, oe, rad};
    endfunction

    // Every-cycle comparison of the DIV = 12 instance against the model.
    always @(negedge clk) begin
        chk("bus_cycle",
            64'({bif.slot_ch, bif.frame, bif.ack, bif.rdata, bif.rmpx, bif.nroe, bif.ra,
                 bif.rad_oe, (bif.rad_oe ? bif.rad_o : 8'h00)}),
            64'(exp_vec(cyc, m_active, m_addr, m_ack, m_rdata, m_frame)));
    end

    task automatic run_to(input int k);
        int guard;
        guard = 0;
        while (cyc != k && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        if (cyc != k) chk("run_to_timeout", 64'(cyc), 64'(k));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish by t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        nreset = 1'b0;
        nreset2 = 1'b0;
        bif.req = 6'b000000;
        bif2.req = 6'b100000;
        for (int i = 0; i < 6; i++) addr_tab[i] = '0;
        repeat (3) @(negedge clk);
        chk("rst_nroe", 64'(bif.nroe), 64'd1);
        chk("rst_rmpx", 64'(bif.rmpx), 64'd0);
        chk("rst_rad_oe", 64'(bif.rad_oe), 64'd0);
        chk("rst_ra", 64'(bif.ra), 64'd0);

        // Idle rotation, interleaved with the DIV = 4 instance
        nreset = 1'b1;
        nreset2 = 1'b1;
        run_to(72);  chk("t1_slot_ch72", 64'(bif.slot_ch), 64'd0);
        run_to(73);  chk("t1_slot_ch73", 64'(bif.slot_ch), 64'd1);
        run_to(120); chk("t6_slot_ch120", 64'(bif2.slot_ch), 64'd4);
        run_to(121); chk("t6_slot_ch121", 64'(bif2.slot_ch), 64'd5);
                     chk("t6_rad121", 64'(bif2.rad_o), 64'hF1);
        run_to(136); chk("t6_nroe136", 64'(bif2.nroe), 64'd1);
        run_to(137); chk("t6_nroe137", 64'(bif2.nroe), 64'd0);
        run_to(144); chk("t6_ack144", 64'(bif2.ack), 64'd0);
        run_to(145); chk("t6_ack145", 64'(bif2.ack), 64'b100000);
                     chk("t6_rdata145", 64'(bif2.rdata), 64'h3C);
        run_to(146); chk("t6_ack146", 64'(bif2.ack), 64'd0);
        run_to(361); chk("t1_slot_ch361", 64'(bif.slot_ch), 64'd5);
        run_to(432); chk("t1_frame432", 64'(bif.frame), 64'd0);
        run_to(433); chk("t1_frame433", 64'(bif.frame), 64'd1);
        run_to(434); chk("t1_frame434", 64'(bif.frame), 64'd0);

        // Single request on channel 0
        nreset = 1'b0;
        bif.req = 6'b000001;
        addr_tab[0] = 22'h2ABCDE;
        repeat (2) @(negedge clk);
        nreset = 1'b1;
        run_to(5);  chk("t2_rad_lo", 64'(bif.rad_o), 64'hDE);
                    chk("t2_ra_lo", 64'(bif.ra), 64'h00);
        run_to(12); chk("t2_rmpx12", 64'(bif.rmpx), 64'd0);
        run_to(13); chk("t2_rmpx13", 64'(bif.rmpx), 64'd1);
        run_to(30); chk("t2_rad_hi", 64'(bif.rad_o), 64'hAF);
                    chk("t2_ra_hi", 64'(bif.ra), 64'h0A);
        run_to(36); chk("t2_rmpx36", 64'(bif.rmpx), 64'd1);
        run_to(37); chk("t2_rmpx37", 64'(bif.rmpx), 64'd0);
        run_to(48); chk("t2_nroe48", 64'(bif.nroe), 64'd1);
        run_to(49); chk("t2_nroe49", 64'(bif.nroe), 64'd0);
        run_to(72); chk("t2_nroe72", 64'(bif.nroe), 64'd0);
        run_to(73); chk("t2_ack73", 64'(bif.ack), 64'b000001);
                    chk("t2_rdata73", 64'(bif.rdata), 64'h5A);
        run_to(74); chk("t2_ack74", 64'(bif.ack), 64'd0);

        // All channels, with channel 3 withdrawn mid-slot
        nreset = 1'b0;
        bif.req = 6'b111111;
        addr_tab[0] = 22'h000123;
        addr_tab[1] = 22'h0ABC45;
        addr_tab[2] = 22'h155667;
        addr_tab[3] = 22'h3FFFFF;
        addr_tab[4] = 22'h200400;
        addr_tab[5] = 22'h1C3E5D;
        repeat (2) @(negedge clk);
        nreset = 1'b1;
        for (int c = 0; c < 6; c++) begin
            if (c == 3) begin
                run_to(245);
                bif.req[3] = 1'b0;
                addr_tab[3] = 22'h012345;
            end
            run_to(73 + 72 * c);
            chk("t3_ack_order", 64'(bif.ack), 64'(6'd1 << c));
        end
        run_to(289 + 72 * 2);
        run_to(700); chk("t4_idle_nroe", 64'(bif.nroe), 64'd1);
        run_to(721); chk("t4_no_ack", 64'(bif.ack), 64'd0);

        // Reset during channel 2's P4
        run_to(1060);
        chk("t5_pre_nroe", 64'(bif.nroe), 64'd0);
        #3;
        nreset = 1'b0;
        #1;
        chk("t5_rst_nroe", 64'(bif.nroe), 64'd1);
        chk("t5_rst_rad_oe", 64'(bif.rad_oe), 64'd0);
        chk("t5_rst_slot_ch", 64'(bif.slot_ch), 64'd0);
        chk("t5_rst_rdata", 64'(bif.rdata), 64'd0);
        repeat (3) @(negedge clk);
        chk("t5_rst_ack", 64'(bif.ack), 64'd0);
        nreset = 1'b1;
        run_to(1);  chk("t5_slot_ch1", 64'(bif.slot_ch), 64'd0);
        run_to(73); chk("t5_ack73", 64'(bif.ack), 64'b000001);
                    chk("t5_rdata73", 64'(bif.rdata), 64'h22);
        run_to(80);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
